// File: rtl/aes_job_issuer.sv
// aes_job_issuer: initiator side of the AES wrapper CSR handshake.
// Takes one-block jobs from the host, applies optional CBC chaining, launches
// the wrapper with a single-cycle start pulse, follows the wrapper's status and
// capture strobes, and returns the result block with an error flag.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. job_ready is high only in IDLE. res_valid stays high, with
// res_data/res_error stable, until the edge where res_ready is also high.
module aes_job_issuer #(
  parameter int TIMEOUT_CYCLES = 4096,  // 0 disables the timeout
  parameter int CNT_W          = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] job_key,
  input  logic [127:0] job_iv,
  input  logic [127:0] job_data,
  input  logic         job_decrypt,
  input  logic         job_cbc,
  input  logic         job_first,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_error,
  output logic         busy,
  output logic [127:0] aes_key,
  output logic [127:0] aes_iv,
  output logic [127:0] aes_plaintext,
  output logic [7:0]   aes_csr,
  input  logic [2:0]   aes_status,
  input  logic         aes_csr_update,
  input  logic         aes_ctrwrite,
  input  logic [127:0] aes_ciphertext,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESULT    = 3'd5
  } state_t;

  // The launch cycle is followed by at most TIMEOUT_CYCLES waiting cycles; a
  // done strobe in the last of them still completes the job normally.
  localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [127:0]       job_data_q;
  logic               cbc_q;
  logic               dec_q;
  logic [127:0]       chain;
  logic [127:0]       cap;
  logic [CNT_W-1:0]   cnt;

  logic [127:0]       chain_next;
  logic               ack_hit;
  logic               done_hit;
  logic [127:0]       fin_data;

  assign job_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Chain value a new job would XOR against, before it is stored.
  assign chain_next = job_first ? job_iv : chain;
  assign ack_hit    = aes_csr_update && (aes_status == 3'd2);
  assign done_hit   = aes_csr_update && (aes_status == 3'd1);
  // CBC decrypt un-chains the wrapper output with the previous ciphertext.
  assign fin_data   = (cbc_q && dec_q) ? (cap ^ chain) : cap;

  // Job sequencing FSM with all wrapper-facing and host-facing outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      job_data_q    <= '0;
      cbc_q         <= 1'b0;
      dec_q         <= 1'b0;
      chain         <= '0;
      cap           <= '0;
      cnt           <= '0;
      aes_key       <= '0;
      aes_iv        <= '0;
      aes_plaintext <= '0;
      aes_csr       <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            job_data_q    <= job_data;
            cbc_q         <= job_cbc;
            dec_q         <= job_decrypt;
            aes_key       <= job_key;
            aes_iv        <= job_iv;
            if (job_cbc && job_first) chain <= job_iv;
            aes_plaintext <= (job_cbc && !job_decrypt) ? (job_data ^ chain_next) : job_data;
            // bit 6 selects decrypt, bit 2 is the start pulse
            aes_csr       <= {1'b0, job_decrypt, 3'b000, 1'b1, 2'b00};
            state         <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // The wrapper restarts on every cycle start is high, so drop it now.
          aes_csr[2] <= 1'b0;
          cnt        <= '0;
          state      <= S_WAIT_ACK;
        end

        S_WAIT_ACK, S_WAIT_DATA, S_WAIT_DONE: begin
          if ((state == S_WAIT_DONE) && done_hit) begin
            res_valid <= 1'b1;
            res_error <= 1'b0;
            res_data  <= fin_data;
            if (cbc_q) chain <= dec_q ? job_data_q : cap;
            state     <= S_RESULT;
          end else if (TMO_EN && (cnt == TMO_LAST)) begin
            res_valid <= 1'b1;
            res_error <= 1'b1;
            res_data  <= '0;
            state     <= S_RESULT;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == S_WAIT_ACK) begin
              // A ciphertext strobe may overtake the busy acknowledge.
              if (aes_ctrwrite) begin
                cap   <= aes_ciphertext;
                state <= S_WAIT_DONE;
              end else if (ack_hit) begin
                state <= S_WAIT_DATA;
              end
            end else if (state == S_WAIT_DATA) begin
              if (aes_ctrwrite) begin
                cap   <= aes_ciphertext;
                state <= S_WAIT_DONE;
              end
            end
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_error <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_issuer.sv
// tb_aes_job_issuer: directed bench for aes_job_issuer with a wrapper stub that
// answers from a table of known AES-128 block pairs.
module tb_aes_job_issuer;

  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         job_valid, job_ready;
  logic [127:0] job_key, job_iv, job_data;
  logic         job_decrypt, job_cbc, job_first;
  logic         res_valid, res_ready, res_error, busy;
  logic [127:0] res_data;
  logic [127:0] aes_key, aes_iv, aes_plaintext, aes_ciphertext;
  logic [7:0]   aes_csr;
  logic [2:0]   aes_status, dbg_state;
  logic         aes_csr_update, aes_ctrwrite;

  // wrapper inputs: stub drive OR'd with manual stray strobes
  logic         stub_upd, stub_ctr, man_upd, man_ctr;
  logic [2:0]   stub_status, man_status;
  logic [127:0] stub_ct, man_ct;
  assign aes_csr_update = stub_upd | man_upd;
  assign aes_ctrwrite   = stub_ctr | man_ctr;
  assign aes_status     = stub_status | man_status;
  assign aes_ciphertext = stub_ct | man_ct;

  aes_job_issuer #(.TIMEOUT_CYCLES(TMO), .CNT_W(13)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_key(job_key), .job_iv(job_iv), .job_data(job_data),
    .job_decrypt(job_decrypt), .job_cbc(job_cbc), .job_first(job_first),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .busy(busy),
    .aes_key(aes_key), .aes_iv(aes_iv), .aes_plaintext(aes_plaintext), .aes_csr(aes_csr),
    .aes_status(aes_status), .aes_csr_update(aes_csr_update), .aes_ctrwrite(aes_ctrwrite),
    .aes_ciphertext(aes_ciphertext), .dbg_state(dbg_state)
  );

  // ---------------- vectors ----------------
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PB  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] XA  = 128'h6bc0bce12a459991e134741a7f9e1925;  // PA ^ IV
  localparam logic [127:0] XB  = 128'hd86421fb9f1a1eda505ee1375746972c;  // PB ^ CA
  localparam logic [127:0] CA  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CB  = 128'h5086cb9b507219ee95db113a917678b2;

  logic [127:0] tk [0:5];
  logic [127:0] ti [0:5];
  logic [127:0] tout [0:5];
  logic         td [0:5];

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad = 0;
  logic [128:0] exp_q[$];
  int           stub_mode = 0;  // 0 answer, 1 silent, 2 ack only
  logic         exp_dec = 1'b0;
  logic [127:0] exp_key = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  // ---------------- wrapper stub ----------------
  // Latches the request on the start pulse, then walks ack, data, a stray
  // busy status during WAIT_DONE, and done.
  initial begin
    logic [127:0] out;
    int           hit;
    stub_upd = 1'b0; stub_ctr = 1'b0; stub_status = '0; stub_ct = '0;
    forever begin
      @(negedge clock);
      if (aes_csr[2] && !reset && stub_mode != 1) begin
        hit = -1;
        out = '0;
        for (int i = 0; i < 6; i++)
          if (tk[i] == aes_key && ti[i] == aes_plaintext && td[i] == aes_csr[6]) begin
            hit = i;
            out = tout[i];
          end
        total++;
        if (hit < 0) begin
          bad++;
          $display("FAIL wrapper_input got=%h want=known block", aes_plaintext);
        end
        @(negedge clock); stub_upd = 1'b1; stub_status = 3'd2;
        @(negedge clock); stub_upd = 1'b0; stub_status = 3'd0;
        if (stub_mode != 2) begin
          stub_ctr = 1'b1; stub_ct = out;
          @(negedge clock); stub_ctr = 1'b0; stub_ct = '0; stub_upd = 1'b1; stub_status = 3'd2;
          @(negedge clock); stub_status = 3'd1;
          @(negedge clock); stub_upd = 1'b0; stub_status = 3'd0;
        end
      end
    end
  end

  // ---------------- monitor: result port ----------------
  initial begin
    logic [128:0] e;
    forever begin
      @(negedge clock);
      if (!reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result got=%h want=none", res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_error", 128'(res_error), 128'(e[128]));
          chk("res_data", res_data, e[127:0]);
        end
      end
    end
  end

  // ---------------- monitor: held request fields, start pulse width ----------------
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clock);
      if (busy) begin
        chk("csr_decrypt_held", 128'(aes_csr[6]), 128'(exp_dec));
        chk("key_held", aes_key, exp_key);
        chk("csr_other_bits", 128'(aes_csr & 8'hbb), 128'(0));
      end
      if (aes_csr[2]) chk("start_single_cycle", 128'(prev_start), 128'(0));
      prev_start = aes_csr[2];
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_job(input logic [127:0] k, input logic [127:0] iv, input logic [127:0] d,
                          input logic dec, input logic cbc, input logic first,
                          input logic err, input logic [127:0] exp_d);
    int n;
    n = 0;
    while (!job_ready && n < 500) begin @(negedge clock); n++; end
    if (!job_ready) begin
      total++; bad++;
      $display("FAIL job_ready_wait got=0 want=1");
      return;
    end
    exp_q.push_back({err, exp_d});
    exp_dec = dec; exp_key = k;
    job_key = k; job_iv = iv; job_data = d;
    job_decrypt = dec; job_cbc = cbc; job_first = first;
    job_valid = 1'b1;
    @(negedge clock);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin @(negedge clock); n++; end
    if (exp_q.size() != 0 || busy) begin
      total++; bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_aes_csr"}, 128'(aes_csr), 128'(0));
    chk({tag, "_aes_key"}, aes_key, '0);
    chk({tag, "_aes_iv"}, aes_iv, '0);
    chk({tag, "_aes_plaintext"}, aes_plaintext, '0);
    chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    chk({tag, "_res_data"}, res_data, '0);
    chk({tag, "_res_error"}, 128'(res_error), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_job_ready"}, 128'(job_ready), 128'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    tk[0] = K1; ti[0] = P1; tout[0] = C1; td[0] = 1'b0;
    tk[1] = K1; ti[1] = C1; tout[1] = P1; td[1] = 1'b1;
    tk[2] = K2; ti[2] = XA; tout[2] = CA; td[2] = 1'b0;
    tk[3] = K2; ti[3] = XB; tout[3] = CB; td[3] = 1'b0;
    tk[4] = K2; ti[4] = CA; tout[4] = XA; td[4] = 1'b1;
    tk[5] = K2; ti[5] = CB; tout[5] = XB; td[5] = 1'b1;

    reset = 1'b1;
    job_valid = 1'b0; job_key = '0; job_iv = '0; job_data = '0;
    job_decrypt = 1'b0; job_cbc = 1'b0; job_first = 1'b0;
    res_ready = 1'b1;
    man_upd = 1'b0; man_ctr = 1'b0; man_status = '0; man_ct = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    // T1 / T2: ECB encrypt then decrypt
    send_job(K1, '0, P1, 1'b0, 1'b0, 1'b0, 1'b0, C1);
    wait_idle();
    send_job(K1, '0, C1, 1'b1, 1'b0, 1'b0, 1'b0, P1);
    wait_idle();

    // T3 first block
    send_job(K2, IV, PA, 1'b0, 1'b1, 1'b1, 1'b0, CA);
    wait_idle();

    // T5: silent wrapper mid-chain, timeout with stray strobes afterwards
    stub_mode = 1;
    res_ready = 1'b0;
    send_job(K2, '0, 128'hdeadbeef, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("t5_start_at_launch", 128'(aes_csr[2]), 128'(1));
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clock); n++; end
    chk("t5_timeout_latency", 128'(n), 128'(TMO + 1));
    man_upd = 1'b1; man_status = 3'd1; man_ctr = 1'b1; man_ct = {128{1'b1}};
    @(negedge clock);
    man_upd = 1'b0; man_status = '0; man_ctr = 1'b0; man_ct = '0;
    @(negedge clock);
    chk("t5_valid_held", 128'(res_valid), 128'(1));
    chk("t5_error_held", 128'(res_error), 128'(1));
    @(posedge clock); #1 res_ready = 1'b1;
    stub_mode = 0;
    wait_idle();
    man_upd = 1'b1; man_status = 3'd1; man_ctr = 1'b1; man_ct = {128{1'b1}};
    @(negedge clock);
    man_upd = 1'b0; man_status = '0; man_ctr = 1'b0; man_ct = '0;
    @(negedge clock);
    chk("idle_strobes_ignored", 128'(busy), 128'(0));

    // T3 second block: chain must still be CA
    send_job(K2, '0, PB, 1'b0, 1'b1, 1'b0, 1'b0, CB);
    wait_idle();

    // T4: CBC decrypt of both blocks
    send_job(K2, IV, CA, 1'b1, 1'b1, 1'b1, 1'b0, PA);
    send_job(K2, '0, CB, 1'b1, 1'b1, 1'b0, 1'b0, PB);
    wait_idle();

    // T6: reset while waiting for data
    stub_mode = 2;
    send_job(K1, IV, P1, 1'b0, 1'b0, 1'b0, 1'b0, C1);
    repeat (2) @(negedge clock);
    chk("t6_in_wait_data", 128'(dbg_state), 128'(3));
    #2 reset = 1'b1;
    #1 check_reset_outputs("midjob");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    stub_mode = 0;
    @(negedge clock);

    // T6: result held while host stalls
    res_ready = 1'b0;
    send_job(K1, '0, P1, 1'b0, 1'b0, 1'b0, 1'b0, C1);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clock); n++; end
    chk("t6_result_arrives", 128'(res_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t6_valid_stable", 128'(res_valid), 128'(1));
      chk("t6_data_stable", res_data, C1);
      chk("t6_job_ready_low", 128'(job_ready), 128'(0));
    end
    @(posedge clock); #1 res_ready = 1'b1;
    wait_idle();
    chk("t6_ready_after", 128'(job_ready), 128'(1));

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
